// File: rtl/regfile_32x64_fwd.sv
`default_nettype none
// ============================================================================
// Module      : regfile_32x64_fwd
// Description : 32 x 64-bit register file with two combinational read ports,
//               one clocked write port, hard-wired zero register X31 and
//               same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_32x64_fwd (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2
);

    localparam int c_DATA_W = 64;
    localparam int c_NREGS  = 32;

    logic [3:0]          w_bank_en;
    logic [c_NREGS-1:0]  w_we;
    logic                w_wr_live;
    logic                w_fwd1;
    logic                w_fwd2;
    logic [c_DATA_W-1:0] r_regs    [0:c_NREGS-2];
    logic [c_DATA_W-1:0] w_rd_view [0:c_NREGS-1];

    // 2-to-4 stage: the upper address bits pick which 3-to-8 decoder is enabled
    always_comb begin
        w_bank_en = '0;
        if (RegWrite) begin
            w_bank_en[WriteRegister[4:3]] = 1'b1;
        end
    end

    // Four enabled 3-to-8 decoders yield a one-hot write enable per register
    generate
        for (genvar b = 0; b < 4; b++) begin : g_bank
            for (genvar s = 0; s < 8; s++) begin : g_sel
                assign w_we[b*8+s] = w_bank_en[b] & (WriteRegister[2:0] == 3'(s));
            end
        end
    endgenerate

    // Storage for X0..X30; reset wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < c_NREGS - 1; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < c_NREGS - 1; k++) begin
                if (w_we[k]) begin
                    r_regs[k] <= WriteData;
                end
            end
        end
    end

    // Read view of the architectural file; slot 31 is the constant-zero XZR
    always_comb begin
        for (int k = 0; k < c_NREGS - 1; k++) begin
            w_rd_view[k] = r_regs[k];
        end
        w_rd_view[c_NREGS-1] = '0;
    end

    // A write is forwardable only outside reset and when it does not target
    // XZR; the XZR decoder output doubles as the "writing to 31" flag.
    assign w_wr_live = RegWrite & reset & ~w_we[c_NREGS-1];
    assign w_fwd1    = w_wr_live & (ReadRegister1 == WriteRegister);
    assign w_fwd2    = w_wr_live & (ReadRegister2 == WriteRegister);

    // Read mux followed by the bypass mux on each port
    assign ReadData1 = w_fwd1 ? WriteData : w_rd_view[ReadRegister1];
    assign ReadData2 = w_fwd2 ? WriteData : w_rd_view[ReadRegister2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_32x64_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_32x64_fwd
// Description : Self-checking bench for regfile_32x64_fwd: table vectors,
//               decode sweep and hand-written forwarding/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_32x64_fwd;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    regfile_32x64_fwd dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    typedef struct {
        logic [63:0] e1;
        logic [63:0] e2;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[11];
    logic [63:0] model [0:31];
    int          n_vec = 0;
    int          n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int tag, input string port, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %h expected %h", tag, port, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [63:0] e1, input logic [63:0] e2, input int tag);
        exp_t e;
        reset         = rst_n;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        e.e1  = e1;
        e.e2  = e2;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "ReadData1", ReadData1, e.e1);
            chk(e.tag, "ReadData2", ReadData2, e.e2);
        end
    endtask

    // Drive after an edge, compare mid-cycle, then let the edge commit
    task automatic apply(input logic rst_n, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [63:0] e1, input logic [63:0] e2, input int tag);
        drive(rst_n, we, wa, wd, r1, r2, e1, e2, tag);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 5'd5,  5'd0,  64'hDEADBEEF_CAFEF00D, 64'h0};
        vt[1]  = '{1'b1, 1'b1, 5'd30, 64'h1,                 5'd5,  5'd30, 64'hDEADBEEF_CAFEF00D, 64'h1};
        vt[2]  = '{1'b1, 1'b0, 5'd30, 64'hFFFFFFFF_FFFFFFFF, 5'd5,  5'd30, 64'hDEADBEEF_CAFEF00D, 64'h1};
        vt[3]  = '{1'b1, 1'b0, 5'd0,  64'h0,                 5'd4,  5'd6,  64'h0,                 64'h0};
        vt[4]  = '{1'b1, 1'b0, 5'd0,  64'h0,                 5'd29, 5'd0,  64'h0,                 64'h0};
        vt[5]  = '{1'b1, 1'b1, 5'd31, 64'hFFFFFFFF_FFFFFFFF, 5'd31, 5'd31, 64'h0,                 64'h0};
        vt[6]  = '{1'b1, 1'b0, 5'd0,  64'hFFFFFFFF_FFFFFFFF, 5'd31, 5'd30, 64'h0,                 64'h1};
        vt[7]  = '{1'b1, 1'b1, 5'd7,  64'hAAAA,              5'd0,  5'd7,  64'h0,                 64'hAAAA};
        vt[8]  = '{1'b1, 1'b0, 5'd0,  64'h0,                 5'd7,  5'd7,  64'hAAAA,              64'hAAAA};
        vt[9]  = '{1'b1, 1'b1, 5'd9,  64'h99,                5'd9,  5'd7,  64'h99,                64'hAAAA};
        vt[10] = '{1'b1, 1'b0, 5'd0,  64'h0,                 5'd9,  5'd31, 64'h99,                64'h0};

        // Initial reset edge; contents before it are undefined, so no check
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;
        @(posedge clk);
        #1;

        // Every address on both ports reads zero after reset
        for (int a = 0; a < 32; a++) begin
            apply(1'b1, 1'b0, 5'd0, 64'h0, 5'(a), 5'(31 - a), 64'h0, 64'h0, 100 + a);
        end

        // Table vectors: write/readback, XZR, single-port forwarding
        for (int i = 0; i < 11; i++) begin
            apply(vt[i].rst_n, vt[i].we, vt[i].wa, vt[i].wd, vt[i].r1, vt[i].r2,
                  vt[i].e1, vt[i].e2, 200 + i);
        end

        // Both ports forward X7 during the write cycle; dropping RegWrite
        // before the edge exposes the stored value again
        drive(1'b1, 1'b1, 5'd7, 64'h5555, 5'd7, 5'd7, 64'h5555, 64'h5555, 500);
        #2;
        compare_head();
        drive(1'b1, 1'b0, 5'd7, 64'h5555, 5'd7, 5'd7, 64'hAAAA, 64'hAAAA, 501);
        #2;
        compare_head();
        @(posedge clk);
        #1;
        apply(1'b1, 1'b0, 5'd0, 64'h0, 5'd7, 5'd5, 64'hAAAA, 64'hDEADBEEF_CAFEF00D, 502);

        // Decode sweep: Xk = k+1, port 2 confirms the previous write landed
        for (int k = 0; k < 31; k++) begin
            apply(1'b1, 1'b1, 5'(k), 64'(k + 1), 5'(k), (k == 0) ? 5'd31 : 5'(k - 1),
                  64'(k + 1), (k == 0) ? 64'h0 : 64'(k), 300 + k);
            model[k] = 64'(k + 1);
        end
        model[31] = 64'h0;
        for (int k = 0; k < 32; k++) begin
            apply(1'b1, 1'b0, 5'd0, 64'h0, 5'(k), 5'((k + 16) % 32),
                  model[k], model[(k + 16) % 32], 400 + k);
        end

        // Reset and write on the same edge: no forwarding, reset wins
        apply(1'b0, 1'b1, 5'd3, 64'hF, 5'd3, 5'd5, model[3], model[5], 600);
        for (int k = 0; k < 32; k++) model[k] = 64'h0;
        apply(1'b1, 1'b0, 5'd0, 64'h0, 5'd3, 5'd5, model[3], model[5], 601);
        apply(1'b1, 1'b0, 5'd0, 64'h0, 5'd30, 5'd0, model[30], model[0], 602);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
